// File: rtl/tx_scheduler.sv
// tx_scheduler: arbitrates the USB transmitter between the handshake
// responder and the host data path, issues one-cycle packet commands,
// watches for the transfer to start, and owns the DATA0/DATA1 toggle.
module tx_scheduler #(
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned TMR_W         = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic [1:0] hs_type,
   output logic       hs_done,
   input  logic       data_req,
   output logic       data_done,
   output logic       data_err,
   input  logic       toggle_ack,
   input  logic       toggle_clear,
   output logic [2:0] tx_packet,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   output logic       data_toggle,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_ACTIVE,
      S_FINISH
   } state_t;

   localparam logic [2:0] PKT_IDLE  = 3'd0;
   localparam logic [2:0] PKT_DATA0 = 3'd1;
   localparam logic [2:0] PKT_DATA1 = 3'd2;
   localparam logic [2:0] PKT_ACK   = 3'd3;
   localparam logic [2:0] PKT_NAK   = 3'd4;
   localparam logic [2:0] PKT_STALL = 3'd5;

   state_t           state_q, state_d;
   logic             owner_hs_q, owner_hs_d;
   logic [2:0]       code_q, code_d;
   logic             err_q, err_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [TMR_W-1:0] timer_inc;

   logic [2:0]       tx_packet_q, tx_packet_d;
   logic             hs_done_q, hs_done_d;
   logic             data_done_q, data_done_d;
   logic             data_err_q, data_err_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic             toggle_q, toggle_d;

   assign timer_inc = timer_q + TMR_W'(1);

   // State, latched request, watchdog and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_hs_q  <= 1'b0;
         code_q      <= PKT_IDLE;
         err_q       <= 1'b0;
         timer_q     <= '0;
         tx_packet_q <= PKT_IDLE;
         hs_done_q   <= 1'b0;
         data_done_q <= 1'b0;
         data_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_hs_q  <= owner_hs_d;
         code_q      <= code_d;
         err_q       <= err_d;
         timer_q     <= timer_d;
         tx_packet_q <= tx_packet_d;
         hs_done_q   <= hs_done_d;
         data_done_q <= data_done_d;
         data_err_q  <= data_err_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic; completion pulses are registered on entry to FINISH
   // so they line up with the FINISH cycle itself
   always_comb begin
      state_d     = state_q;
      owner_hs_d  = owner_hs_q;
      code_d      = code_q;
      err_d       = err_q;
      timer_d     = timer_q;
      tx_packet_d = PKT_IDLE;
      hs_done_d   = 1'b0;
      data_done_d = 1'b0;
      data_err_d  = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            err_d = 1'b0;
            if (hs_req) begin
               owner_hs_d = 1'b1;
               case (hs_type)
                  2'd0:    code_d = PKT_ACK;
                  2'd2:    code_d = PKT_STALL;
                  default: code_d = PKT_NAK;
               endcase
               state_d = S_ISSUE;
            end else if (data_req) begin
               owner_hs_d = 1'b0;
               code_d     = toggle_q ? PKT_DATA1 : PKT_DATA0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tx_packet_d = code_q;
            timer_d     = '0;
            state_d     = S_WAIT_START;
         end
         S_WAIT_START: begin
            timer_d = timer_inc;
            if (tx_error) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else if (tx_transfer_active) begin
               state_d = S_ACTIVE;
            end else if (timer_inc == TMR_W'(START_TIMEOUT)) begin
               timeout_d = 1'b1;
               err_d     = 1'b1;
               state_d   = S_FINISH;
            end
         end
         S_ACTIVE: begin
            if (tx_error) begin
               err_d = 1'b1;
            end
            if (!tx_transfer_active) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_FINISH && state_q != S_FINISH) begin
         hs_done_d   = owner_hs_d;
         data_done_d = !owner_hs_d;
         data_err_d  = !owner_hs_d && err_d;
      end

      busy_d = (state_d != S_IDLE);
   end

   // DATA0/DATA1 toggle; clear wins over ack
   always_comb begin
      toggle_d = toggle_q;
      if (toggle_clear) begin
         toggle_d = 1'b0;
      end else if (toggle_ack) begin
         toggle_d = !toggle_q;
      end
   end

   // Toggle register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign tx_packet   = tx_packet_q;
   assign hs_done     = hs_done_q;
   assign data_done   = data_done_q;
   assign data_err    = data_err_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_q;
   assign data_toggle = toggle_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed and randomized transfers against a timeline
// model of the scheduler. Inputs are driven and outputs sampled on the
// falling clock edge; cycle 0 of a transfer is the cycle the request is
// first presented.
module tb_tx_scheduler;
   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       hs_req;
   logic [1:0] hs_type;
   logic       hs_done;
   logic       data_req;
   logic       data_done;
   logic       data_err;
   logic       toggle_ack;
   logic       toggle_clear;
   logic [2:0] tx_packet;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       data_toggle;
   logic       busy;
   logic       timeout_err;

   int n_cmp = 0;
   int n_err = 0;
   bit model_tog = 1'b0;

   tx_scheduler #(
      .START_TIMEOUT(TO),
      .TMR_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hs_req(hs_req),
      .hs_type(hs_type),
      .hs_done(hs_done),
      .data_req(data_req),
      .data_done(data_done),
      .data_err(data_err),
      .toggle_ack(toggle_ack),
      .toggle_clear(toggle_clear),
      .tx_packet(tx_packet),
      .tx_transfer_active(tx_transfer_active),
      .tx_error(tx_error),
      .data_toggle(data_toggle),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] e_tx, input bit e_busy,
                             input bit e_hsd, input bit e_dd, input bit e_de, input bit e_to);
      chk({tag, ".tx_packet"}, 8'(tx_packet), 8'(e_tx));
      chk({tag, ".busy"}, 8'(busy), 8'(e_busy));
      chk({tag, ".hs_done"}, 8'(hs_done), 8'(e_hsd));
      chk({tag, ".data_done"}, 8'(data_done), 8'(e_dd));
      chk({tag, ".data_err"}, 8'(data_err), 8'(e_de));
      chk({tag, ".timeout_err"}, 8'(timeout_err), 8'(e_to));
      chk({tag, ".data_toggle"}, 8'(data_toggle), 8'(model_tog));
   endtask

   function automatic logic [2:0] hs_code(input logic [1:0] t);
      case (t)
         2'd0:    return 3'd3;
         2'd2:    return 3'd5;
         default: return 3'd4;
      endcase
   endfunction

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outs($sformatf("%s.idle%0d", tag, i), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         toggle_ack   = 1'b0;
         toggle_clear = 1'b0;
      end
   endtask

   task automatic tpulse(input bit a, input bit c);
      @(negedge clk);
      check_outs("tpulse", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      toggle_ack   = a;
      toggle_clear = c;
      if (c) model_tog = 1'b0;
      else if (a) model_tog = ~model_tog;
   endtask

   // One transfer. d: active rises at cycle 2+d (d<0: never). L: active
   // length. e: cycle of a one-cycle tx_error (-1: none).
   task automatic xfer(input string tag, input bit own_hs, input bit set_hs, input logic [1:0] htype,
                       input bit set_data, input int d, input int L, input int e,
                       input int ack_cyc, input bit hs_early_drop);
      int a, f, fin;
      bit err, tmo;
      logic [2:0] code;
      a = 2 + d;
      f = a + L;
      if (e >= 2 && (d < 0 || e <= a)) begin
         fin = e + 1; err = 1'b1; tmo = 1'b0;
      end else if (d < 0) begin
         fin = 2 + TO; err = 1'b1; tmo = 1'b1;
      end else begin
         fin = f + 1; err = (e > a && e <= f); tmo = 1'b0;
      end
      code = own_hs ? hs_code(htype) : (model_tog ? 3'd2 : 3'd1);
      for (int c = 0; c <= fin; c++) begin
         @(negedge clk);
         check_outs($sformatf("%s.c%0d", tag, c), (c == 2) ? code : 3'd0, c >= 1,
                    own_hs && c == fin, !own_hs && c == fin,
                    !own_hs && c == fin && err, tmo && c == fin);
         if (c == 0) begin
            if (set_hs) begin
               hs_req  = 1'b1;
               hs_type = htype;
            end
            if (set_data) data_req = 1'b1;
         end
         tx_transfer_active = (d >= 0 && c >= a && c < f && c < fin);
         tx_error           = (c == e);
         toggle_ack         = (c == ack_cyc);
         toggle_clear       = 1'b0;
         if (c == ack_cyc) model_tog = ~model_tog;
         if (c == 1 && hs_early_drop) hs_req = 1'b0;
         if (c == fin) begin
            if (own_hs) hs_req = 1'b0;
            else data_req = 1'b0;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int own, mode, d, L, e, ack, a;
      rst = 1'b1;
      hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0;
      toggle_ack = 1'b0; toggle_clear = 1'b0;
      tx_transfer_active = 1'b0; tx_error = 1'b0;

      // Reset values
      #2;
      check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle(2, "post_reset");

      // Basic DATA0 transfer: active 3 cycles after command for 10 cycles
      xfer("data0", 1'b0, 1'b0, 2'd0, 1'b1, 3, 10, -1, -1, 1'b0);

      // Simultaneous STALL handshake and data request: handshake first
      xfer("dual_hs", 1'b1, 1'b1, 2'd2, 1'b1, 1, 2, -1, -1, 1'b0);
      xfer("dual_data", 1'b0, 1'b0, 2'd0, 1'b0, 2, 3, -1, -1, 1'b0);

      // Toggle ack selects DATA1; ack+clear together leaves DATA0
      tpulse(1'b1, 1'b0);
      xfer("data1", 1'b0, 1'b0, 2'd0, 1'b1, 0, 4, -1, -1, 1'b0);
      tpulse(1'b1, 1'b1);
      idle(1, "tog_clear");

      // Start watchdog expiry
      xfer("timeout", 1'b0, 1'b0, 2'd0, 1'b1, -1, 0, -1, -1, 1'b0);

      // Transmitter error mid-transfer; reserved handshake type maps to NAK
      xfer("act_err", 1'b0, 1'b0, 2'd0, 1'b1, 3, 3, 6, -1, 1'b0);
      xfer("hs_rsvd", 1'b1, 1'b1, 2'd3, 1'b0, 0, 1, -1, -1, 1'b1);

      // Toggle change while a data packet is in flight
      xfer("ack_inflight", 1'b0, 1'b0, 2'd0, 1'b1, 2, 2, -1, 1, 1'b0);

      // Reset during ACTIVE
      tpulse(1'b1, 1'b0);
      @(negedge clk);
      data_req = 1'b1; toggle_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tx_transfer_active = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid.busy_before", 8'(busy), 8'd1);
      rst = 1'b1;
      model_tog = 1'b0;
      #1;
      check_outs("rst_mid.async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      data_req = 1'b0;
      tx_transfer_active = 1'b0;
      @(negedge clk);
      check_outs("rst_mid.held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(3, "rst_mid");
      xfer("after_rst", 1'b0, 1'b0, 2'd0, 1'b1, 1, 2, -1, -1, 1'b0);

      // Randomized transfers
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0)
            tpulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         own  = $urandom_range(0, 1);
         mode = $urandom_range(0, 3);
         d    = $urandom_range(0, 12);
         L    = $urandom_range(1, 10);
         a    = 2 + d;
         e    = -1;
         if (mode == 1) e = $urandom_range(2, a);
         else if (mode == 2 && L >= 2) e = $urandom_range(a + 1, a + L - 1);
         else if (mode == 3) d = -1;
         ack  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
         xfer($sformatf("rnd%0d", i), own[0], own[0], 2'($urandom_range(0, 3)), !own[0],
              d, L, e, ack, own[0] && ($urandom_range(0, 1) == 1));
      end
      idle(2, "end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
